// File: rtl/particle_pkg.sv
// Shared particle types: binary16 alias, BRAM word field positions and
// the dispatcher FSM encoding, plus a round-to-nearest-even binary16 multiply.
package particle_pkg;

  typedef logic [15:0] float16_t;

  localparam int WEIGHT_MSB = 31;
  localparam int WEIGHT_LSB = 16;
  localparam int VALUE_MSB  = 15;
  localparam int VALUE_LSB  = 0;

  localparam float16_t FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ZERO  = 2'd3
  } disp_state_e;

  // Subnormal inputs and results flush to signed zero; NaN results are canonical 0x7E00.
  function automatic float16_t fp16_mul(input float16_t a, input float16_t b);
    logic              sign;
    logic [4:0]        ea;
    logic [4:0]        eb;
    logic              a_zero;
    logic              b_zero;
    logic              a_inf;
    logic              b_inf;
    logic              a_nan;
    logic              b_nan;
    logic [21:0]       prod;
    logic [9:0]        mant;
    logic              guard;
    logic              sticky;
    logic [10:0]       mant_rnd;
    logic signed [7:0] exp_s;
    float16_t          res;

    sign   = a[15] ^ b[15];
    ea     = a[14:10];
    eb     = b[14:10];
    a_zero = (ea == 5'd0);
    b_zero = (eb == 5'd0);
    a_inf  = (ea == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (eb == 5'h1F) && (b[9:0] == 10'd0);
    a_nan  = (ea == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (eb == 5'h1F) && (b[9:0] != 10'd0);

    prod  = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    exp_s = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
    if (prod[21]) begin
      mant   = prod[20:11];
      guard  = prod[10];
      sticky = |prod[9:0];
      exp_s  = exp_s + 8'sd1;
    end else begin
      mant   = prod[19:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
    mant_rnd = {1'b0, mant} + {10'd0, guard & (sticky | mant[0])};
    if (mant_rnd[10]) exp_s = exp_s + 8'sd1;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = 16'h7E00;
    else if (a_inf || b_inf)                                        res = {sign, 5'h1F, 10'd0};
    else if (a_zero || b_zero)                                      res = {sign, 15'd0};
    else if (exp_s >= 8'sd31)                                       res = {sign, 5'h1F, 10'd0};
    else if (exp_s <= 8'sd0)                                        res = {sign, 15'd0};
    else                                                            res = {sign, exp_s[4:0], mant_rnd[9:0]};
    return res;
  endfunction

endpackage

// File: rtl/term_dispatcher_if.sv
// BRAM read port and accumulator term stream of the term dispatcher.
// master = dispatcher side, slave = BRAM/accumulator side.
interface term_dispatcher_if
  import particle_pkg::*;
#(
  parameter int IDX_W = 6
);
  logic             rd_en_out;
  logic [IDX_W-1:0] rd_addr_out;
  logic [31:0]      rd_data_in;
  float16_t         term_out;
  logic             term_valid_out;
  logic             terms_in_flight_out;

  modport master (
    output rd_en_out, rd_addr_out, term_out, term_valid_out, terms_in_flight_out,
    input  rd_data_in
  );

  modport slave (
    input  rd_en_out, rd_addr_out, term_out, term_valid_out, terms_in_flight_out,
    output rd_data_in
  );
endinterface

// File: rtl/term_dispatcher_mul.sv
// binary16_multiplier: fully pipelined binary16 product, fixed MUL_LATENCY cycles
// from data_valid_in to data_valid_out.
module binary16_multiplier
  import particle_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic     clk_in,
  input  logic     rst,
  input  float16_t a,
  input  float16_t b,
  input  logic     data_valid_in,
  output float16_t result,
  output logic     data_valid_out
);

  float16_t               res_q [MUL_LATENCY];
  float16_t               res_d [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] vld_q;
  logic [MUL_LATENCY-1:0] vld_d;

  // Product is formed in the first stage; later stages only carry it.
  always_comb begin
    res_d[0] = data_valid_in ? fp16_mul(a, b) : FP16_ZERO;
    for (int i = 1; i < MUL_LATENCY; i++) res_d[i] = res_q[i-1];
    vld_d = {vld_q[MUL_LATENCY-2:0], data_valid_in};
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) res_q[i] <= FP16_ZERO;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < MUL_LATENCY; i++) res_q[i] <= res_d[i];
    end
  end

  assign result         = res_q[MUL_LATENCY-1];
  assign data_valid_out = vld_q[MUL_LATENCY-1];

endmodule

// File: rtl/term_dispatcher.sv
// Walks neighbour indices of one particle, multiplies weight*value and streams terms.
// Optional build macro SKIP_SELF_EN: skip the main particle's own index.
//
// state    | meaning
// IDLE     | waiting for start_in
// ISSUE    | one BRAM read per cycle, ascending index
// DRAIN    | waiting for outstanding terms to leave the pipeline
// ZERO     | emitting the single 0x0000 term of an empty job
module term_dispatcher
  import particle_pkg::*;
#(
  parameter int  MAX_PARTICLES = 64,
  parameter int  READ_LATENCY  = 2,
  parameter int  MUL_LATENCY   = 4,
  localparam int IDX_W         = $clog2(MAX_PARTICLES)
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start_in,
  input  logic [IDX_W-1:0]   main_index_in,
  input  logic [IDX_W:0]     particle_count_in,
  term_dispatcher_if.master  bus,
  output logic               busy_out,
  output logic               done_out
);

`ifdef SKIP_SELF_EN
  localparam bit SKIP_SELF = 1'b1;
`else
  localparam bit SKIP_SELF = 1'b0;
`endif

  localparam logic [IDX_W:0] ONE_W = {{IDX_W{1'b0}}, 1'b1};

  disp_state_e             state_q, state_d;
  logic [IDX_W-1:0]        j_q, j_d;
  logic [IDX_W-1:0]        main_q, main_d;
  logic [IDX_W:0]          count_q, count_d;
  logic [IDX_W:0]          outst_q, outst_d;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  float16_t                term_q, term_d;
  logic                    term_vld_q, term_vld_d;

  logic           issue;
  logic           skip_cur;
  logic           skip_next;
  logic [IDX_W:0] addr_w;
  logic [IDX_W:0] addr_inc;
  logic [IDX_W:0] addr_nx_w;
  logic           last_issue;
  logic [IDX_W:0] eff_cnt;
  logic           term_dec;
  logic           pipe_empty;
  float16_t       mul_res;
  logic           mul_vld;

  // A skipped index is jumped over in the same cycle, so issues never bubble.
  assign issue      = (state_q == ST_ISSUE);
  assign skip_cur   = SKIP_SELF && (j_q == main_q);
  assign addr_w     = {1'b0, j_q} + {{IDX_W{1'b0}}, skip_cur};
  assign addr_inc   = addr_w + ONE_W;
  assign skip_next  = SKIP_SELF && (addr_inc == {1'b0, main_q});
  assign addr_nx_w  = addr_inc + {{IDX_W{1'b0}}, skip_next};
  assign last_issue = (addr_nx_w >= count_q);
  assign eff_cnt    = (SKIP_SELF && ({1'b0, main_index_in} < particle_count_in))
                      ? particle_count_in - ONE_W : particle_count_in;

  // The ZERO term never went through a read, so it must not retire an outstanding issue.
  assign term_dec   = term_vld_q && (state_q != ST_ZERO);
  assign pipe_empty = (outst_q == '0) && !term_vld_q && (rd_vld_q == '0);

  binary16_multiplier #(.MUL_LATENCY(MUL_LATENCY)) u_mul (
    .clk_in         (clk_in),
    .rst            (rst),
    .a              (bus.rd_data_in[WEIGHT_MSB:WEIGHT_LSB]),
    .b              (bus.rd_data_in[VALUE_MSB:VALUE_LSB]),
    .data_valid_in  (rd_vld_q[READ_LATENCY-1]),
    .result         (mul_res),
    .data_valid_out (mul_vld)
  );

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    main_d     = main_q;
    count_d    = count_q;
    term_d     = mul_vld ? mul_res : FP16_ZERO;
    term_vld_d = mul_vld;
    rd_vld_d   = {rd_vld_q[READ_LATENCY-2:0], issue};

    unique case ({issue, term_dec})
      2'b10:   outst_d = outst_q + ONE_W;
      2'b01:   outst_d = outst_q - ONE_W;
      default: outst_d = outst_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          main_d  = main_index_in;
          count_d = particle_count_in;
          j_d     = '0;
          if (eff_cnt == '0) begin
            state_d    = ST_ZERO;
            term_d     = FP16_ZERO;
            term_vld_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        j_d = addr_nx_w[IDX_W-1:0];
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_ZERO:  state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      j_q        <= '0;
      main_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      rd_vld_q   <= '0;
      term_q     <= FP16_ZERO;
      term_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      main_q     <= main_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      rd_vld_q   <= rd_vld_d;
      term_q     <= term_d;
      term_vld_q <= term_vld_d;
    end
  end

  assign bus.rd_en_out           = issue;
  assign bus.rd_addr_out         = issue ? addr_w[IDX_W-1:0] : '0;
  assign bus.term_out            = term_q;
  assign bus.term_valid_out      = term_vld_q;
  assign bus.terms_in_flight_out = issue || (state_q == ST_ZERO) ||
                                   ((state_q == ST_DRAIN) && !pipe_empty);
  assign busy_out                = (state_q != ST_IDLE);
  assign done_out                = (state_q == ST_DRAIN) && pipe_empty;

endmodule

// File: tb/tb_term_dispatcher.sv
// Scoreboard bench for term_dispatcher: stimulus queues expected addresses and
// terms (with their cycle), monitors pop and compare as the DUT presents them.
module tb_term_dispatcher;
  import particle_pkg::*;

  localparam int MAXP  = 64;
  localparam int IDX_W = 6;
`ifdef SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             start_in = 1'b0;
  logic [IDX_W-1:0] main_index_in = '0;
  logic [IDX_W:0]   particle_count_in = '0;
  logic             busy_out;
  logic             done_out;

  term_dispatcher_if #(.IDX_W(IDX_W)) bus();

  term_dispatcher #(.MAX_PARTICLES(MAXP), .READ_LATENCY(2), .MUL_LATENCY(4)) dut (
    .clk_in            (clk_in),
    .rst               (rst),
    .start_in          (start_in),
    .main_index_in     (main_index_in),
    .particle_count_in (particle_count_in),
    .bus               (bus),
    .busy_out          (busy_out),
    .done_out          (done_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // BRAM model with two cycles of read latency
  logic [31:0]       mem [MAXP];
  float16_t          exp_prod [MAXP];
  logic [1:0][31:0]  rd_pipe;
  always @(posedge clk_in) begin
    rd_pipe[0] <= bus.rd_en_out ? mem[bus.rd_addr_out] : 32'h0;
    rd_pipe[1] <= rd_pipe[0];
  end
  assign bus.rd_data_in = rd_pipe[1];

  typedef struct {
    float16_t val;
    int       at;
  } exp_t;

  exp_t term_q[$];
  int   addr_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (bus.term_valid_out === 1'b1) begin
      if (term_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL term_unexpected: got term %0h expected none (cycle %0d)", bus.term_out, cyc);
      end else begin
        e = term_q.pop_front();
        check("term_value", bus.term_out, e.val);
        check("term_cycle", cyc, e.at);
      end
    end
    if (bus.rd_en_out === 1'b1) begin
      if (addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_unexpected: got addr %0d expected none (cycle %0d)", bus.rd_addr_out, cyc);
      end else begin
        check("rd_addr", bus.rd_addr_out, addr_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rd_en"}, bus.rd_en_out, 0);
    check({name, "_rd_addr"}, bus.rd_addr_out, 0);
    check({name, "_term"}, bus.term_out, 0);
    check({name, "_term_valid"}, bus.term_valid_out, 0);
    check({name, "_in_flight"}, bus.terms_in_flight_out, 0);
    check({name, "_busy"}, busy_out, 0);
    check({name, "_done"}, done_out, 0);
  endtask

  // Queue the expected reads/terms, run one job and check control timing every cycle.
  task automatic run_job(input int idx, input int cnt, input bit poke);
    int t0;
    int n;
    int done_cyc;
    t0 = cyc;
    n  = 0;
    for (int j = 0; j < cnt; j++) begin
      if (SKIP && j == idx) continue;
      addr_q.push_back(j);
      term_q.push_back('{val: exp_prod[j], at: t0 + 8 + n});
      n++;
    end
    if (n == 0) begin
      term_q.push_back('{val: FP16_ZERO, at: t0 + 1});
      done_cyc = t0 + 2;
    end else begin
      done_cyc = t0 + 8 + n;
    end
    start_in          = 1'b1;
    main_index_in     = IDX_W'(idx);
    particle_count_in = (IDX_W+1)'(cnt);
    tick();
    start_in = 1'b0;
    while (cyc <= done_cyc + 1) begin
      check("busy", busy_out, cyc <= done_cyc);
      check("in_flight", bus.terms_in_flight_out, cyc < done_cyc);
      check("done", done_out, cyc == done_cyc);
      check("rd_en", bus.rd_en_out, (n > 0) && (cyc <= t0 + n));
      if (poke && cyc == t0 + 3) begin
        start_in          = 1'b1;
        main_index_in     = '0;
        particle_count_in = '0;
      end else begin
        start_in = 1'b0;
      end
      tick();
    end
    start_in = 1'b0;
    check("terms_drained", term_q.size(), 0);
    check("reads_drained", addr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < MAXP; j++) begin
      mem[j]      = 32'h0;
      exp_prod[j] = FP16_ZERO;
    end
    rst = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // 1.0 * 2.0
    mem[0] = {16'h3C00, 16'h4000}; exp_prod[0] = 16'h4000;
    run_job(5, 1, 1'b0);

    // 2.0 * 2.0 on every word
    for (int j = 0; j < 4; j++) begin
      mem[j] = {16'h4000, 16'h4000}; exp_prod[j] = 16'h4400;
    end
    run_job(9, 4, 1'b0);

    // mixed products, start pulsed mid-job must be ignored
    mem[0] = {16'h4000, 16'h4000}; exp_prod[0] = 16'h4400;
    mem[1] = {16'h3E00, 16'h3E00}; exp_prod[1] = 16'h4080;
    mem[2] = {16'hC000, 16'h4200}; exp_prod[2] = 16'hC600;
    mem[3] = {16'h0000, 16'h4000}; exp_prod[3] = 16'h0000;
    run_job(9, 4, 1'b1);

    // self index inside the range, then the single-self case
    run_job(2, 4, 1'b0);
    run_job(0, 1, 1'b0);

    // empty job
    run_job(0, 0, 1'b0);

    // reset during issue: five reads happen, nothing reaches the term port
    begin
      int t0;
      t0 = cyc;
      for (int j = 0; j < 5; j++) addr_q.push_back(j);
      start_in          = 1'b1;
      main_index_in     = 6'd20;
      particle_count_in = 7'd8;
      tick();
      start_in = 1'b0;
      while (cyc < t0 + 5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
        check_idle_outputs("after_rst");
        tick();
      end
      check("rst_reads", addr_q.size(), 0);
      check("rst_terms", term_q.size(), 0);
    end
    run_job(3, 4, 1'b0);

    // full particle range: identity weight, distinct values
    for (int j = 0; j < MAXP; j++) begin
      mem[j]      = {16'h3C00, 16'h4000 + 16'(j)};
      exp_prod[j] = 16'h4000 + 16'(j);
    end
    run_job(10, MAXP, 1'b0);
    tick();
    check_idle_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
